// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores to a variable-latency data memory over req/ready,
// extends load data, selects the writeback value and stalls the pipe while waiting.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INST       = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] inst_ex_mem,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_addr,
    input  logic        rd_we,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic [31:0] mem_data_mem,
    output logic [4:0]  mem_addr_mem,
    output logic        mem_we_mem,
    output logic [31:0] inst_mem_wb,
    output logic        mem_stall,
    output logic        mem_fault
);

    localparam int unsigned       CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, wdata_q;
    logic [3:0]       be_q;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic             latch_en;

    logic             is_store, is_load, f3_legal, misaligned, req_ok;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;

    function automatic logic [31:0] load_ext(input logic [31:0] rdata,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
        logic [31:0] s;
        s = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'd0, s[7:0]};
            3'b101:  return {16'd0, s[15:0]};
            default: return rdata;
        endcase
    endfunction

    always_comb begin
        is_store = ex_valid & mem_write;
        is_load  = ex_valid & mem_read & ~mem_write;
        if (is_store) f3_legal = ~funct3[2] & (funct3[1:0] != 2'b11);
        else          f3_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        case (funct3[1:0])
            2'b01:   misaligned = alu_result[0];
            2'b10:   misaligned = |alu_result[1:0];
            default: misaligned = 1'b0;
        endcase
        req_ok = (is_store | is_load) & f3_legal & ~misaligned;
        case (funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << alu_result[1:0];
                wdata_c = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << alu_result[1:0];
                wdata_c = {2{store_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = store_data;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        latch_en     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        dmem_be      = '0;
        mem_data_mem = '0;
        mem_addr_mem = '0;
        mem_we_mem   = 1'b0;
        inst_mem_wb  = NOP_INST;
        mem_stall    = 1'b0;
        mem_fault    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (is_store | is_load) begin
                        if (!req_ok) begin
                            mem_fault = 1'b1;
                        end else begin
                            dmem_req   = 1'b1;
                            dmem_we    = is_store;
                            dmem_addr  = {alu_result[31:2], 2'b00};
                            dmem_wdata = wdata_c;
                            dmem_be    = be_c;
                            latch_en   = 1'b1;
                            if (dmem_ready) begin
                                mem_addr_mem = rd_addr;
                                inst_mem_wb  = inst_ex_mem;
                                if (is_load) begin
                                    mem_data_mem = load_ext(dmem_rdata, funct3, alu_result[1:0]);
                                    mem_we_mem   = rd_we;
                                end
                            end else begin
                                mem_stall = 1'b1;
                                state_d   = WAIT;
                                cnt_d     = CNT_W'(1);
                            end
                        end
                    end else begin
                        mem_data_mem = alu_result;
                        mem_addr_mem = rd_addr;
                        mem_we_mem   = rd_we;
                        inst_mem_wb  = inst_ex_mem;
                    end
                end
            end
            WAIT: begin
                // Request held from the latches so the memory sees a stable access
                dmem_req   = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = addr_q;
                dmem_wdata = wdata_q;
                dmem_be    = be_q;
                if (dmem_ready) begin
                    mem_addr_mem = rd_addr;
                    inst_mem_wb  = inst_ex_mem;
                    if (!we_q) begin
                        mem_data_mem = load_ext(dmem_rdata, f3_q, off_q);
                        mem_we_mem   = rd_we;
                    end
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LIMIT) begin
                    mem_fault = 1'b1;
                    state_d   = IDLE;
                    cnt_d     = '0;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (!reset) begin
            dmem_req     = 1'b0;
            dmem_we      = 1'b0;
            dmem_addr    = '0;
            dmem_wdata   = '0;
            dmem_be      = '0;
            mem_data_mem = '0;
            mem_addr_mem = '0;
            mem_we_mem   = 1'b0;
            inst_mem_wb  = '0;
            mem_stall    = 1'b0;
            mem_fault    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                addr_q  <= {alu_result[31:2], 2'b00};
                wdata_q <= wdata_c;
                be_q    <= be_c;
                we_q    <= is_store;
                f3_q    <= funct3;
                off_q   <= alu_result[1:0];
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: vector table, multi-cycle corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_mem_access_stage;

    localparam int unsigned T   = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, rd_we, mem_read, mem_write, dmem_ready;
    logic [31:0] inst_ex_mem, alu_result, store_data, dmem_rdata;
    logic [4:0]  rd_addr;
    logic [2:0]  funct3;
    logic        dmem_req, dmem_we, mem_we_mem, mem_stall, mem_fault;
    logic [31:0] dmem_addr, dmem_wdata, mem_data_mem, inst_mem_wb;
    logic [3:0]  dmem_be;
    logic [4:0]  mem_addr_mem;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(T), .NOP_INST(NOP)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .inst_ex_mem(inst_ex_mem),
        .alu_result(alu_result), .store_data(store_data), .rd_addr(rd_addr), .rd_we(rd_we),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .mem_data_mem(mem_data_mem), .mem_addr_mem(mem_addr_mem), .mem_we_mem(mem_we_mem),
        .inst_mem_wb(inst_mem_wb), .mem_stall(mem_stall), .mem_fault(mem_fault)
    );

    typedef struct packed {
        logic ev; logic [31:0] inst; logic [31:0] alu; logic [31:0] sd; logic [4:0] rd;
        logic rwe; logic mr; logic mw; logic [2:0] f3; logic [31:0] rdata; logic rdy;
    } stim_t;

    typedef struct packed {
        logic req; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;
        logic [31:0] data; logic [4:0] rd; logic wem; logic [31:0] inst; logic stall; logic fault;
    } obs_t;

    typedef struct { string name; stim_t s; obs_t e; obs_t m; } vec_t;

    obs_t act;
    assign act = {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, mem_data_mem,
                  mem_addr_mem, mem_we_mem, inst_mem_wb, mem_stall, mem_fault};

    int checks = 0;
    int errors = 0;

    function automatic stim_t mk_stim(logic ev, logic [31:0] inst, logic [31:0] alu, logic [31:0] sd,
                                      logic [4:0] rd, logic rwe, logic mr, logic mw, logic [2:0] f3,
                                      logic [31:0] rdata, logic rdy);
        return {ev, inst, alu, sd, rd, rwe, mr, mw, f3, rdata, rdy};
    endfunction

    function automatic obs_t mk_obs(logic req, logic we, logic [31:0] addr, logic [31:0] wdata,
                                    logic [3:0] be, logic [31:0] data, logic [4:0] rd, logic wem,
                                    logic [31:0] inst, logic stall, logic fault);
        return {req, we, addr, wdata, be, data, rd, wem, inst, stall, fault};
    endfunction

    // dmem: we/addr care, lane: wdata/be care, wb: data/rd care
    function automatic obs_t mk_mask(bit dmem, bit lane, bit wb);
        obs_t m;
        m = '1;
        if (!dmem) begin m.we = 1'b0; m.addr = '0; end
        if (!lane) begin m.wdata = '0; m.be = '0; end
        if (!wb)   begin m.data = '0; m.rd = '0; end
        return m;
    endfunction

    task automatic drive(input stim_t s);
        ex_valid = s.ev; inst_ex_mem = s.inst; alu_result = s.alu; store_data = s.sd;
        rd_addr = s.rd; rd_we = s.rwe; mem_read = s.mr; mem_write = s.mw; funct3 = s.f3;
        dmem_rdata = s.rdata; dmem_ready = s.rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input obs_t e, input obs_t m);
        checks++;
        if (((act ^ e) & m) != '0) begin
            errors++;
            $display("FAIL %s: got req=%b we=%b addr=%h wdata=%h be=%b data=%h rd=%0d wem=%b inst=%h stall=%b fault=%b ; expected req=%b we=%b addr=%h wdata=%h be=%b data=%h rd=%0d wem=%b inst=%h stall=%b fault=%b (care %h)",
                     name, act.req, act.we, act.addr, act.wdata, act.be, act.data, act.rd, act.wem,
                     act.inst, act.stall, act.fault, e.req, e.we, e.addr, e.wdata, e.be, e.data,
                     e.rd, e.wem, e.inst, e.stall, e.fault, m);
        end
    endtask

    // ---------------- reference model (byte-lane arithmetic, transaction level) ----------------
    function automatic int unsigned nbytes(logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] rdata, logic [2:0] f3, logic [31:0] addr);
        int unsigned n = nbytes(f3);
        logic [31:0] keep, v;
        if (n == 4) return rdata;
        keep = (32'd1 << (8 * n)) - 32'd1;
        v = (rdata >> (8 * (addr % 4))) & keep;
        if (!f3[2] && v[8 * n - 1]) v = v | ~keep;
        return v;
    endfunction

    function automatic logic [31:0] model_wdata(logic [31:0] sd, logic [2:0] f3);
        int unsigned n = nbytes(f3);
        logic [31:0] w = '0;
        for (int l = 0; l < 4; l++) w = w | (((sd >> (8 * (l % n))) & 32'hFF) << (8 * l));
        return w;
    endfunction

    function automatic logic [3:0] model_be(logic [2:0] f3, logic [31:0] addr);
        int unsigned b = ((1 << nbytes(f3)) - 1) << (addr % 4);
        return b[3:0];
    endfunction

    bit          pend = 0;
    int unsigned waited;
    logic [31:0] p_addr;
    logic [2:0]  p_f3;
    bit          p_store;

    task automatic model_step(input stim_t s, output obs_t e, output obs_t m);
        bit store, legal, aligned, finish;
        logic [31:0] addr;
        logic [2:0]  f3;
        e = '0; e.inst = NOP; m = '1; finish = 0;
        addr = s.alu; f3 = s.f3; store = s.mw;
        if (!pend) begin
            if (s.ev && (s.mr || s.mw)) begin
                legal   = store ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                aligned = legal && (addr % nbytes(f3) == 0);
                if (!aligned) begin
                    e.fault = 1'b1; m = mk_mask(0, 0, 0);
                end else begin
                    e.req = 1'b1; e.we = store; e.addr = addr & ~32'd3;
                    e.wdata = model_wdata(s.sd, f3); e.be = model_be(f3, addr);
                    if (s.rdy) finish = 1;
                    else begin
                        e.stall = 1'b1; pend = 1; waited = 1;
                        p_addr = addr; p_f3 = f3; p_store = store;
                    end
                end
            end else if (s.ev) begin
                e.data = s.alu; e.rd = s.rd; e.wem = s.rwe; e.inst = s.inst;
            end
        end else begin
            addr = p_addr; f3 = p_f3; store = p_store;
            e.req = 1'b1; e.we = store; e.addr = addr & ~32'd3;
            e.wdata = model_wdata(s.sd, f3); e.be = model_be(f3, addr);
            m.wdata = '0;  // latched lanes come from the issue-cycle store data
            if (s.rdy) begin
                finish = 1; pend = 0;
            end else if (waited == T) begin
                e.fault = 1'b1; pend = 0;
                m = mk_mask(0, 0, 1); m.req = 1'b0;
            end else begin
                e.stall = 1'b1; waited++;
            end
        end
        if (finish) begin
            e.inst = s.inst; e.rd = s.rd;
            if (store) begin
                e.wem = 1'b0; m.data = '0; m.rd = '0;
            end else begin
                e.wem = s.rwe; e.data = model_load(s.rdata, f3, addr);
            end
        end
        if (!store) begin m.wdata = '0; m.be = '0; end
        if (!e.req) begin m.we = 1'b0; m.addr = '0; m.wdata = '0; m.be = '0; end
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        int unsigned kind = $urandom_range(0, 3);
        s.ev = ($urandom_range(0, 7) != 0);
        s.inst = $urandom; s.alu = $urandom; s.sd = $urandom; s.rd = 5'($urandom);
        s.rwe = 1'($urandom); s.mr = (kind == 1 || kind == 3); s.mw = (kind >= 2);
        s.f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
        if ($urandom_range(0, 1) == 0) s.alu[1:0] = 2'b00;
        s.rdata = $urandom; s.rdy = 1'b0;
        return s;
    endfunction

    vec_t  vecs [$];
    obs_t  e, m;
    stim_t s;

    initial begin
        // ---------------- reset holds every output at zero ----------------
        reset = 1'b0;
        drive(mk_stim(1, 32'h00002003, 32'h100, 0, 5'd4, 1, 1, 0, 3'd2, 32'h55, 1));
        #1 check("reset_outputs", '0, '1);
        next_cycle();
        check("reset_outputs_clocked", '0, '1);
        next_cycle();
        reset = 1'b1;

        // ---------------- single-cycle vector table ----------------
        vecs.push_back('{"alu_op", mk_stim(1, 32'h00A28293, 32'h1234, 0, 5, 1, 0, 0, 0, 32'hFFFFFFFF, 1),
            mk_obs(0, 0, 0, 0, 0, 32'h1234, 5, 1, 32'h00A28293, 0, 0), mk_mask(0, 0, 1)});
        vecs.push_back('{"lb_zero_wait", mk_stim(1, 32'h10300383, 32'h103, 0, 7, 1, 1, 0, 3'd0, 32'h80000000, 1),
            mk_obs(1, 0, 32'h100, 0, 0, 32'hFFFFFF80, 7, 1, 32'h10300383, 0, 0), mk_mask(1, 0, 1)});
        vecs.push_back('{"lbu_zero_wait", mk_stim(1, 32'h10304383, 32'h103, 0, 7, 1, 1, 0, 3'd4, 32'h80000000, 1),
            mk_obs(1, 0, 32'h100, 0, 0, 32'h00000080, 7, 1, 32'h10304383, 0, 0), mk_mask(1, 0, 1)});
        vecs.push_back('{"sb_lane1", mk_stim(1, 32'h0AB008A3, 32'h11, 32'hAB, 0, 0, 0, 1, 3'd0, 0, 1),
            mk_obs(1, 1, 32'h10, 32'hABABABAB, 4'b0010, 0, 0, 0, 32'h0AB008A3, 0, 0), mk_mask(1, 1, 0)});
        vecs.push_back('{"sw_misaligned", mk_stim(1, 32'h00F02323, 32'h6, 32'h77, 0, 0, 0, 1, 3'd2, 0, 0),
            mk_obs(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 1), mk_mask(0, 0, 0)});
        vecs.push_back('{"load_f3_011", mk_stim(1, 32'h00003083, 32'h0, 0, 1, 1, 1, 0, 3'd3, 0, 1),
            mk_obs(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 1), mk_mask(0, 0, 0)});
        vecs.push_back('{"store_f3_100", mk_stim(1, 32'h00004023, 32'h0, 1, 0, 0, 0, 1, 3'd4, 0, 1),
            mk_obs(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 1), mk_mask(0, 0, 0)});
        vecs.push_back('{"lh_misaligned", mk_stim(1, 32'h20101083, 32'h201, 0, 1, 1, 1, 0, 3'd1, 0, 0),
            mk_obs(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 1), mk_mask(0, 0, 0)});
        vecs.push_back('{"lw_misaligned", mk_stim(1, 32'h10202083, 32'h102, 0, 1, 1, 1, 0, 3'd2, 0, 1),
            mk_obs(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 1), mk_mask(0, 0, 0)});
        vecs.push_back('{"both_store_f3_100", mk_stim(1, 32'h00004083, 32'h40, 0, 1, 1, 1, 1, 3'd4, 0, 1),
            mk_obs(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 1), mk_mask(0, 0, 0)});
        vecs.push_back('{"both_store_wins_sh", mk_stim(1, 32'h02201123, 32'h22, 32'h12345678, 2, 1, 1, 1, 3'd1, 32'h99, 1),
            mk_obs(1, 1, 32'h20, 32'h56785678, 4'b1100, 0, 0, 0, 32'h02201123, 0, 0), mk_mask(1, 1, 0)});
        vecs.push_back('{"sw_zero_wait", mk_stim(1, 32'h04002023, 32'h40, 32'hDEADBEEF, 0, 0, 0, 1, 3'd2, 0, 1),
            mk_obs(1, 1, 32'h40, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 32'h04002023, 0, 0), mk_mask(1, 1, 0)});
        vecs.push_back('{"lw_zero_wait", mk_stim(1, 32'h08002F83, 32'h80, 0, 31, 1, 1, 0, 3'd2, 32'hCAFEBABE, 1),
            mk_obs(1, 0, 32'h80, 0, 0, 32'hCAFEBABE, 31, 1, 32'h08002F83, 0, 0), mk_mask(1, 0, 1)});
        vecs.push_back('{"lhu_upper", mk_stim(1, 32'h20205083, 32'h202, 0, 1, 1, 1, 0, 3'd5, 32'h80010000, 1),
            mk_obs(1, 0, 32'h200, 0, 0, 32'h00008001, 1, 1, 32'h20205083, 0, 0), mk_mask(1, 0, 1)});
        vecs.push_back('{"lh_pos", mk_stim(1, 32'h20001083, 32'h200, 0, 1, 1, 1, 0, 3'd1, 32'h00007FFF, 1),
            mk_obs(1, 0, 32'h200, 0, 0, 32'h00007FFF, 1, 1, 32'h20001083, 0, 0), mk_mask(1, 0, 1)});
        vecs.push_back('{"lh_neg", mk_stim(1, 32'h20001083, 32'h200, 0, 1, 1, 1, 0, 3'd1, 32'h00008000, 1),
            mk_obs(1, 0, 32'h200, 0, 0, 32'hFFFF8000, 1, 1, 32'h20001083, 0, 0), mk_mask(1, 0, 1)});
        vecs.push_back('{"lb_offset1", mk_stim(1, 32'h10100083, 32'h101, 0, 1, 1, 1, 0, 3'd0, 32'h00007F00, 1),
            mk_obs(1, 0, 32'h100, 0, 0, 32'h0000007F, 1, 1, 32'h10100083, 0, 0), mk_mask(1, 0, 1)});
        vecs.push_back('{"lw_no_rd_we", mk_stim(1, 32'h00002003, 32'h0, 0, 3, 0, 1, 0, 3'd2, 32'h01020304, 1),
            mk_obs(1, 0, 32'h0, 0, 0, 32'h01020304, 3, 0, 32'h00002003, 0, 0), mk_mask(1, 0, 1)});
        vecs.push_back('{"ex_invalid", mk_stim(0, 32'h00002003, 32'h100, 5, 3, 1, 1, 0, 3'd2, 32'h1, 1),
            mk_obs(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0), mk_mask(1, 1, 1)});

        foreach (vecs[i]) begin
            drive(vecs[i].s);
            @(negedge clk);
            check(vecs[i].name, vecs[i].e, vecs[i].m);
            next_cycle();
        end

        // ---------------- 3-wait LH; latched offset survives input changes ----------------
        drive(mk_stim(1, 32'h20209483, 32'h202, 0, 9, 1, 1, 0, 3'd1, 0, 0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("lh_wait_stall", mk_obs(1, 0, 32'h200, 0, 0, 0, 0, 0, NOP, 1, 0), mk_mask(1, 0, 1));
            next_cycle();
            alu_result = 32'h00000FFF;
        end
        dmem_ready = 1'b1; dmem_rdata = 32'hBEEF0000;
        @(negedge clk);
        check("lh_wait_done", mk_obs(1, 0, 32'h200, 0, 0, 32'hFFFFBEEF, 9, 1, 32'h20209483, 0, 0), mk_mask(1, 0, 1));
        next_cycle();

        // ---------------- timeout, then a stray ready is ignored ----------------
        drive(mk_stim(1, 32'h30002023, 32'h300, 32'h11223344, 0, 0, 0, 1, 3'd2, 0, 0));
        for (int c = 0; c < int'(T); c++) begin
            @(negedge clk);
            check("timeout_stall", mk_obs(1, 1, 32'h300, 32'h11223344, 4'hF, 0, 0, 0, NOP, 1, 0), mk_mask(1, 1, 1));
            next_cycle();
        end
        @(negedge clk);
        e = mk_obs(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 1);
        m = mk_mask(0, 0, 1); m.req = 1'b0;
        check("timeout_fault", e, m);
        next_cycle();
        drive(mk_stim(0, 32'h0, 32'h300, 0, 0, 0, 0, 0, 3'd0, 32'hFFFFFFFF, 1));
        @(negedge clk);
        check("stray_ready_after_timeout", mk_obs(0, 0, 0, 0, 0, 0, 0, 0, NOP, 0, 0), mk_mask(1, 1, 1));
        next_cycle();

        // ---------------- reset asserted while waiting ----------------
        drive(mk_stim(1, 32'h40002283, 32'h400, 0, 5, 1, 1, 0, 3'd2, 0, 0));
        @(negedge clk);
        check("rst_wait_issue", mk_obs(1, 0, 32'h400, 0, 0, 0, 0, 0, NOP, 1, 0), mk_mask(1, 0, 1));
        next_cycle();
        @(negedge clk);
        check("rst_wait_in_wait", mk_obs(1, 0, 32'h400, 0, 0, 0, 0, 0, NOP, 1, 0), mk_mask(1, 0, 1));
        #2 reset = 1'b0;
        #1 check("rst_wait_async_drop", '0, '1);
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("rst_wait_back_idle", mk_obs(1, 0, 32'h400, 0, 0, 0, 0, 0, NOP, 1, 0), mk_mask(1, 0, 1));
        next_cycle();
        dmem_ready = 1'b1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        check("rst_wait_complete", mk_obs(1, 0, 32'h400, 0, 0, 32'h12345678, 5, 1, 32'h40002283, 0, 0), mk_mask(1, 0, 1));
        next_cycle();

        // ---------------- randomized traffic vs reference model ----------------
        pend = 0;
        begin
            bit held = 0;
            int unsigned rp = 100;
            int unsigned probs [4] = '{0, 25, 60, 100};
            for (int c = 0; c < 800; c++) begin
                if (!held) begin
                    s  = rand_stim();
                    rp = probs[$urandom_range(0, 3)];
                end
                s.rdata = $urandom;
                s.rdy   = ($urandom_range(0, 99) < rp);
                drive(s);
                @(negedge clk);
                model_step(s, e, m);
                check("random", e, m);
                held = e.stall;
                next_cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
